// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator: integer+fractional divisor, mid-bit
// sample pulse, end-of-bit pulse, resync for RX start-edge phase alignment.
module baud_tick_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int DEF_DIV  = 434,
  parameter int DEF_FRAC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              sample_pulse,
  output logic              bit_pulse,
  output logic              cfg_err
);

  // ST_ARM: next RUN cycle is cnt=0 of a fresh period whose length is not yet latched
  typedef enum logic {ST_ARM, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    pint_q, pint_d, aint_q, aint_d, cnt_q, cnt_d;
  logic [FRAC_W-1:0]   pfrac_q, pfrac_d, afrac_q, afrac_d, acc_q, acc_d;
  logic [DIV_W:0]      len_q, len_d, len_cur, len_start, len_wrap;
  logic [FRAC_W:0]     sum_start, sum_wrap;
  logic                samp_q, samp_d, bit_q, bit_d, err_q, err_d;
  logic                at_mid, at_end;

  assign sum_start = {1'b0, acc_q} + {1'b0, afrac_q};
  assign sum_wrap  = {1'b0, acc_q} + {1'b0, pfrac_q};
  assign len_start = {1'b0, aint_q} + {{DIV_W{1'b0}}, sum_start[FRAC_W]};
  // at a wrap the pending divisor becomes active, so the next length uses it directly
  assign len_wrap  = {1'b0, pint_q} + {{DIV_W{1'b0}}, sum_wrap[FRAC_W]};
  assign len_cur   = (state_q == ST_RUN) ? len_q : len_start;
  assign at_mid    = ({1'b0, cnt_q} == (len_cur >> 1));
  assign at_end    = ({1'b0, cnt_q} == (len_cur - {{DIV_W{1'b0}}, 1'b1}));

  always_comb begin
    state_d = state_q;
    pint_d  = pint_q;
    pfrac_d = pfrac_q;
    aint_d  = aint_q;
    afrac_d = afrac_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    len_d   = len_q;
    samp_d  = 1'b0;
    bit_d   = 1'b0;
    err_d   = err_q;

    if (div_load) begin
      pfrac_d = div_frac;
      if (div_int < DIV_W'(4)) begin
        pint_d = DIV_W'(4);
        err_d  = 1'b1;
      end else begin
        pint_d = div_int;
        err_d  = 1'b0;
      end
    end

    if (!baud_en || resync) begin
      state_d = ST_ARM;
      cnt_d   = '0;
      acc_d   = '0;
      aint_d  = pint_q;
      afrac_d = pfrac_q;
    end else begin
      samp_d = at_mid;
      bit_d  = at_end;
      if (at_end) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        aint_d  = pint_q;
        afrac_d = pfrac_q;
        acc_d   = sum_wrap[FRAC_W-1:0];
        len_d   = len_wrap;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == ST_ARM) begin
          state_d = ST_RUN;
          acc_d   = sum_start[FRAC_W-1:0];
          len_d   = len_start;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      pint_q  <= DIV_W'(DEF_DIV);
      aint_q  <= DIV_W'(DEF_DIV);
      pfrac_q <= FRAC_W'(DEF_FRAC);
      afrac_q <= FRAC_W'(DEF_FRAC);
      cnt_q   <= '0;
      acc_q   <= '0;
      len_q   <= (DIV_W+1)'(DEF_DIV);
      samp_q  <= 1'b0;
      bit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pint_q  <= pint_d;
      aint_q  <= aint_d;
      pfrac_q <= pfrac_d;
      afrac_q <= afrac_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end

  assign sample_pulse = samp_q;
  assign bit_pulse    = bit_q;
  assign cfg_err      = err_q;

endmodule
